sal_axi_rd_slave: RTL and testbench

- AXI read-channel responder: the target end of the AR/R channels that the bench drives with read-address transfers.
- Accepts AR requests, splits each burst into per-beat internal read requests toward the scheduler/DFI read path, collects in-order read data, and returns R beats with ID/RLAST/RRESP under R-channel backpressure.
- Sits at the AXI front of SAL_DDR_CTRL, between axi_ar_if/axi_r_if and the controller's request queue.

---
 rtl/sal_axi_rd_slave_pkg.sv | 41 ++++
 rtl/sal_axi_rd_slave_if.sv | 41 ++++
 rtl/sal_sync_fifo.sv | 46 ++++
 rtl/sal_axi_rd_slave.sv | 146 ++++++++++++++
 tb/tb_sal_axi_rd_slave.sv | 388 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sal_axi_rd_slave_pkg.sv
// Shared types and encodings for the AXI read responder.
// Widths, burst/resp codes and the AR/issue/track bundles.
package sal_axi_rd_slave_pkg;

    localparam int ID_W   = 4;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 128;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [ADDR_W-1:0] addr;
        logic [3:0]        len;
        logic [2:0]        size;
        logic [1:0]        burst;
    } axi_ar_cmd_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [3:0]        len;
        logic [2:0]        size;
        logic [1:0]        burst;
    } rd_issue_t;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [3:0]      len;
        logic            err;
    } rd_track_t;

    function automatic logic burst_ok(input logic [1:0] b);
        return (b == BURST_INCR) || (b == BURST_FIXED);
    endfunction

endpackage

// File: rtl/sal_axi_rd_slave_if.sv
// AR/R channel plus internal per-beat request/response bundle.
// slave = responder side, master = requester/memory side.
interface sal_axi_rd_slave_if;
    import sal_axi_rd_slave_pkg::*;

    logic              arvalid;
    logic              arready;
    logic [ID_W-1:0]   arid;
    logic [ADDR_W-1:0] araddr;
    logic [3:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;

    logic              rvalid;
    logic              rready;
    logic [ID_W-1:0]   rid;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;

    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;

    modport slave (
        input  arvalid, arid, araddr, arlen, arsize, arburst,
        input  rready, req_ready, rsp_valid, rsp_data,
        output arready, rvalid, rid, rdata, rresp, rlast,
        output req_valid, req_addr
    );

    modport master (
        output arvalid, arid, araddr, arlen, arsize, arburst,
        output rready, req_ready, rsp_valid, rsp_data,
        input  arready, rvalid, rid, rdata, rresp, rlast,
        input  req_valid, req_addr
    );

endinterface

// File: rtl/sal_sync_fifo.sv
// Synchronous show-ahead FIFO, DEPTH a power of 2 (>= 2).
// Push is ignored when full, pop is ignored when empty.
module sal_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wptr_q, rptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign full_o  = (wptr_q[AW] != rptr_q[AW]) &&
                     (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty_o = (wptr_q == rptr_q);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = mem_q[rptr_q[AW-1:0]];

    // Pointer update; the extra MSB separates full from empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
        end
    end

    // Storage write, no reset needed on the data array.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/sal_axi_rd_slave.sv
// AXI read responder: splits AR bursts into per-beat requests,
// buffers in-order read data and returns R beats under backpressure.
module sal_axi_rd_slave
    import sal_axi_rd_slave_pkg::*;
#(
    parameter int CMD_DEPTH  = 4,
    parameter int DATA_DEPTH = 16
) (
    input logic               clk,
    input logic               rst_n,
    sal_axi_rd_slave_if.slave bus
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_ISSUE = 1'b1;
    localparam int         CW      = $clog2(DATA_DEPTH) + 1;

    axi_ar_cmd_t       ar_cmd;
    rd_issue_t         iss_in, iss_head;
    rd_track_t         trk_in, trk_head;
    logic              ar_hs;
    logic              iss_full, iss_empty, iss_pop;
    logic              trk_full, trk_empty, trk_pop;
    logic              dbuf_full, dbuf_empty, dbuf_pop;
    logic [DATA_W-1:0] dbuf_head;

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        beat_q, beat_d;
    logic [3:0]        len_q, len_d;
    logic [2:0]        size_q, size_d;
    logic              fixed_q, fixed_d;
    logic [CW-1:0]     credit_q, credit_d;
    logic [3:0]        rbeat_q, rbeat_d;
    logic              req_hs, r_hs, trk_vld;

    assign ar_cmd = '{id: bus.arid, addr: bus.araddr, len: bus.arlen,
                      size: bus.arsize, burst: bus.arburst};
    assign iss_in = '{addr: ar_cmd.addr, len: ar_cmd.len,
                      size: ar_cmd.size, burst: ar_cmd.burst};
    assign trk_in = '{id: ar_cmd.id, len: ar_cmd.len,
                      err: !burst_ok(ar_cmd.burst)};

    assign bus.arready = !iss_full && !trk_full;
    assign ar_hs       = bus.arvalid && bus.arready;

    sal_sync_fifo #(.WIDTH($bits(rd_issue_t)), .DEPTH(CMD_DEPTH)) u_iss (
        .clk, .rst_n, .push_i(ar_hs), .data_i(iss_in), .pop_i(iss_pop),
        .data_o(iss_head), .full_o(iss_full), .empty_o(iss_empty)
    );

    // Twice as deep as the issue FIFO so new bursts can be accepted
    // while earlier ones are still draining on R.
    sal_sync_fifo #(.WIDTH($bits(rd_track_t)), .DEPTH(2*CMD_DEPTH)) u_trk (
        .clk, .rst_n, .push_i(ar_hs), .data_i(trk_in), .pop_i(trk_pop),
        .data_o(trk_head), .full_o(trk_full), .empty_o(trk_empty)
    );

    sal_sync_fifo #(.WIDTH(DATA_W), .DEPTH(DATA_DEPTH)) u_dbuf (
        .clk, .rst_n, .push_i(bus.rsp_valid), .data_i(bus.rsp_data),
        .pop_i(dbuf_pop), .data_o(dbuf_head), .full_o(dbuf_full),
        .empty_o(dbuf_empty)
    );

    assign bus.req_valid = (state_q == S_ISSUE) && (credit_q != '0);
    assign bus.req_addr  = addr_q;
    assign req_hs        = bus.req_valid && bus.req_ready;

    // Issue FSM: load a burst in IDLE, emit one request per beat in ISSUE.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        beat_d  = beat_q;
        len_d   = len_q;
        size_d  = size_q;
        fixed_d = fixed_q;
        iss_pop = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!iss_empty) begin
                    iss_pop = 1'b1;
                    addr_d  = iss_head.addr;
                    beat_d  = '0;
                    len_d   = iss_head.len;
                    size_d  = iss_head.size;
                    fixed_d = (iss_head.burst == BURST_FIXED);
                    if (burst_ok(iss_head.burst)) state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (req_hs) begin
                    if (!fixed_q) addr_d = addr_q + (ADDR_W'(1) << size_q);
                    if (beat_q == len_q) state_d = S_IDLE;
                    else                 beat_d  = beat_q + 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign trk_vld    = !trk_empty;
    assign bus.rvalid = trk_vld && (trk_head.err || !dbuf_empty);
    assign bus.rlast  = bus.rvalid && (rbeat_q == trk_head.len);
    assign bus.rid    = trk_vld ? trk_head.id : '0;
    assign bus.rresp  = (trk_vld && trk_head.err) ? RESP_SLVERR : RESP_OKAY;
    assign bus.rdata  = (trk_vld && !trk_head.err && !dbuf_empty)
                        ? dbuf_head : '0;
    assign r_hs       = bus.rvalid && bus.rready;
    assign dbuf_pop   = r_hs && !trk_head.err;
    assign trk_pop    = r_hs && bus.rlast;

    // Credits reserve a buffer slot per issued beat; R pops return them.
    always_comb begin
        credit_d = credit_q - CW'(req_hs) + CW'(dbuf_pop);
        rbeat_d  = rbeat_q;
        if (r_hs) rbeat_d = bus.rlast ? 4'd0 : rbeat_q + 4'd1;
    end

    // State registers for issue FSM, credits and R beat counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            beat_q   <= '0;
            len_q    <= '0;
            size_q   <= '0;
            fixed_q  <= 1'b0;
            credit_q <= CW'(DATA_DEPTH);
            rbeat_q  <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            beat_q   <= beat_d;
            len_q    <= len_d;
            size_q   <= size_d;
            fixed_q  <= fixed_d;
            credit_q <= credit_d;
            rbeat_q  <= rbeat_d;
        end
    end

    // Read data must never arrive into a full buffer.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(bus.rsp_valid && dbuf_full));

endmodule

// File: tb/tb_sal_axi_rd_slave.sv
// Bench for sal_axi_rd_slave: queue-based reference model,
// per-cycle output compare, directed cases and random traffic.
module tb_sal_axi_rd_slave;
    import sal_axi_rd_slave_pkg::*;

    localparam int CMD_DEPTH  = 4;
    localparam int DATA_DEPTH = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sal_axi_rd_slave_if bus ();

    sal_axi_rd_slave #(.CMD_DEPTH(CMD_DEPTH), .DATA_DEPTH(DATA_DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    int errs = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [3:0]  id;
        logic [31:0] addr;
        int          len;
        int          size;
        logic [1:0]  burst;
    } mcmd_t;
    typedef struct {
        logic [3:0] id;
        int         len;
        bit         err;
    } mtrk_t;
    typedef struct {
        logic [3:0]   id;
        logic [127:0] data;
        logic [1:0]   resp;
        bit           last;
    } rlog_t;

    mcmd_t        iss[$];
    mtrk_t        trk[$];
    logic [127:0] dq[$];
    int           pend[$];
    logic [31:0]  req_log[$];
    rlog_t        r_log[$];

    int          credit, rbeat, cyc, last_due, cur_left, cur_size;
    bit          act, cur_fixed;
    logic [31:0] cur_addr;
    int          rsp_lat_max = 0;
    bit          pat = 1'b0;
    int          rready_pct = 100;
    int          reqr_pct = 100;

    logic         e_arready, e_req_valid, e_rvalid, e_rlast, h_err;
    logic [3:0]   e_rid;
    logic [127:0] e_rdata;
    logic [1:0]   e_rresp;
    mcmd_t        c;
    mtrk_t        t;
    rlog_t        rl;
    int           d;

    always @(negedge clk) begin
        if (!rst_n) begin
            iss.delete(); trk.delete(); dq.delete(); pend.delete();
            credit = DATA_DEPTH; act = 0; rbeat = 0; last_due = -1;
        end else begin
            cyc++;
            e_arready = (iss.size() < CMD_DEPTH) && (trk.size() < 2*CMD_DEPTH);
            e_req_valid = act && (credit > 0);
            e_rvalid = 0; e_rid = 0; e_rdata = 0; e_rresp = 0;
            e_rlast = 0; h_err = 0;
            if (trk.size() > 0) begin
                h_err   = trk[0].err;
                e_rvalid = h_err || (dq.size() > 0);
                e_rid   = trk[0].id;
                e_rresp = h_err ? RESP_SLVERR : RESP_OKAY;
                e_rdata = (!h_err && dq.size() > 0) ? dq[0] : '0;
                e_rlast = (rbeat == trk[0].len);
            end
            chk("arready", bus.arready, e_arready);
            chk("req_valid", bus.req_valid, e_req_valid);
            if (e_req_valid) chk("req_addr", bus.req_addr, cur_addr);
            chk("rvalid", bus.rvalid, e_rvalid);
            if (e_rvalid) begin
                chk("rid", bus.rid, e_rid);
                chk("rdata", bus.rdata, e_rdata);
                chk("rresp", bus.rresp, e_rresp);
                chk("rlast", bus.rlast, e_rlast);
            end
            if (bus.req_valid && bus.req_ready) req_log.push_back(bus.req_addr);
            if (bus.rvalid && bus.rready) begin
                rl.id = bus.rid; rl.data = bus.rdata;
                rl.resp = bus.rresp; rl.last = bus.rlast;
                r_log.push_back(rl);
            end
            // issue side: one beat per accepted request, bubble between bursts
            if (act) begin
                if (e_req_valid && bus.req_ready) begin
                    credit--;
                    d = cyc + $urandom_range(0, rsp_lat_max);
                    if (d <= last_due) d = last_due + 1;
                    last_due = d;
                    pend.push_back(d);
                    if (!cur_fixed) cur_addr = cur_addr + (32'd1 << cur_size);
                    if (cur_left == 0) act = 0;
                    else cur_left--;
                end
            end else if (iss.size() > 0) begin
                c = iss.pop_front();
                if (c.burst == BURST_INCR || c.burst == BURST_FIXED) begin
                    act = 1; cur_addr = c.addr; cur_left = c.len;
                    cur_size = c.size; cur_fixed = (c.burst == BURST_FIXED);
                end
            end
            // return side
            if (e_rvalid && bus.rready) begin
                if (!h_err) begin
                    void'(dq.pop_front());
                    credit++;
                end
                if (e_rlast) begin
                    void'(trk.pop_front());
                    rbeat = 0;
                end else rbeat++;
            end
            if (bus.rsp_valid) dq.push_back(bus.rsp_data);
            if (bus.arvalid && e_arready) begin
                c.id = bus.arid; c.addr = bus.araddr; c.len = int'(bus.arlen);
                c.size = int'(bus.arsize); c.burst = bus.arburst;
                iss.push_back(c);
                t.id = bus.arid; t.len = int'(bus.arlen);
                t.err = !(bus.arburst == BURST_INCR || bus.arburst == BURST_FIXED);
                trk.push_back(t);
            end
        end
    end

    // in-order memory responder, latency drawn when the request is taken
    initial begin
        bus.rsp_valid = 0;
        bus.rsp_data = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                pend.delete();
                bus.rsp_valid = 0;
            end else if (pend.size() > 0 && pend[0] <= cyc) begin
                void'(pend.pop_front());
                bus.rsp_valid = 1;
                bus.rsp_data = pat ? {4{32'hA5A5_A5A5}}
                             : {$urandom, $urandom, $urandom, $urandom};
            end else bus.rsp_valid = 0;
        end
    end

    // ready throttling
    initial begin
        bus.rready = 1;
        bus.req_ready = 1;
        forever begin
            @(posedge clk);
            #1;
            bus.rready = ($urandom_range(0, 99) < rready_pct);
            bus.req_ready = ($urandom_range(0, 99) < reqr_pct);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_ar(input logic [3:0] id, input logic [31:0] addr,
                         input logic [3:0] len, input logic [2:0] size,
                         input logic [1:0] burst);
        bus.arvalid = 1; bus.arid = id; bus.araddr = addr;
        bus.arlen = len; bus.arsize = size; bus.arburst = burst;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (bus.arready) begin
                step();
                bus.arvalid = 0;
                return;
            end
            step();
        end
        bus.arvalid = 0;
        checks++; errs++;
        $display("FAIL ar_accept: arready stayed 0, want 1 within 400 cycles");
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (iss.size() == 0 && trk.size() == 0 && !act &&
                pend.size() == 0 && dq.size() == 0) begin
                step();
                return;
            end
        end
        checks++; errs++;
        $display("FAIL drain: still busy after %0d cycles, want idle", budget);
    endtask

    task automatic clr_logs();
        req_log.delete();
        r_log.delete();
    endtask

    int          r;
    logic [1:0]  b;
    logic [31:0] a;

    initial begin
        bus.arvalid = 0; bus.arid = 0; bus.araddr = 0;
        bus.arlen = 0; bus.arsize = 0; bus.arburst = 0;
        cyc = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_arready", bus.arready, 1'b1);
        chk("rst_rvalid", bus.rvalid, 1'b0);
        chk("rst_rlast", bus.rlast, 1'b0);
        chk("rst_req_valid", bus.req_valid, 1'b0);
        chk("rst_rid", bus.rid, 4'h0);
        chk("rst_rdata", bus.rdata, 128'h0);
        chk("rst_rresp", bus.rresp, 2'b00);
        chk("rst_req_addr", bus.req_addr, 32'h0);
        @(negedge clk);
        #2 rst_n = 1;
        step();

        // single beat, data one cycle after request
        clr_logs(); pat = 1; rsp_lat_max = 0;
        do_ar(4'd0, 32'h0, 4'd0, 3'd4, BURST_INCR);
        wait_idle(200);
        chk("t1_nbeats", r_log.size(), 1);
        if (r_log.size() == 1) begin
            chk("t1_rdata", r_log[0].data, {4{32'hA5A5_A5A5}});
            chk("t1_rid", r_log[0].id, 4'd0);
            chk("t1_rresp", r_log[0].resp, RESP_OKAY);
            chk("t1_rlast", r_log[0].last, 1'b1);
        end
        pat = 0; rsp_lat_max = 3;

        // INCR len=3 size=4
        clr_logs();
        do_ar(4'd3, 32'h100, 4'd3, 3'd4, BURST_INCR);
        wait_idle(200);
        chk("t2_nreq", req_log.size(), 4);
        chk("t2_nbeats", r_log.size(), 4);
        for (int i = 0; i < 4 && i < req_log.size(); i++)
            chk("t2_req_addr", req_log[i], 32'h100 + 32'(16 * i));
        for (int i = 0; i < 4 && i < r_log.size(); i++) begin
            chk("t2_rlast", r_log[i].last, (i == 3));
            chk("t2_rid", r_log[i].id, 4'd3);
        end

        // two bursts under 20 cycles of R stall
        clr_logs(); rready_pct = 0;
        do_ar(4'd1, 32'h200, 4'd1, 3'd4, BURST_INCR);
        do_ar(4'd2, 32'h300, 4'd0, 3'd4, BURST_INCR);
        repeat (20) step();
        rready_pct = 100;
        wait_idle(200);
        chk("t3_nbeats", r_log.size(), 3);
        if (r_log.size() == 3) begin
            chk("t3_id0", r_log[0].id, 4'd1);
            chk("t3_id1", r_log[1].id, 4'd1);
            chk("t3_id2", r_log[2].id, 4'd2);
            chk("t3_last0", r_log[0].last, 1'b0);
            chk("t3_last1", r_log[1].last, 1'b1);
            chk("t3_last2", r_log[2].last, 1'b1);
        end

        // credit ceiling: 32 beats requested, only 16 outstanding
        clr_logs(); rready_pct = 0;
        do_ar(4'd5, 32'h1000, 4'd15, 3'd4, BURST_INCR);
        do_ar(4'd6, 32'h2000, 4'd15, 3'd4, BURST_INCR);
        repeat (60) step();
        chk("t3b_stall_nreq", req_log.size(), DATA_DEPTH);
        rready_pct = 100;
        wait_idle(500);
        chk("t3b_total_nreq", req_log.size(), 32);
        chk("t3b_nbeats", r_log.size(), 32);

        // AR FIFO fills while requests are blocked
        reqr_pct = 0;
        for (int i = 0; i < 5; i++)
            do_ar(4'(i), 32'h400 + 32'(i * 16), 4'd0, 3'd4, BURST_INCR);
        @(negedge clk);
        chk("t4_arready_full", bus.arready, 1'b0);
        step();
        reqr_pct = 100;
        wait_idle(300);

        // WRAP: no requests, SLVERR beats with zero data
        clr_logs();
        do_ar(4'd7, 32'h500, 4'd1, 3'd4, BURST_WRAP);
        wait_idle(100);
        chk("t5_nreq", req_log.size(), 0);
        chk("t5_nbeats", r_log.size(), 2);
        if (r_log.size() == 2) begin
            chk("t5_resp0", r_log[0].resp, RESP_SLVERR);
            chk("t5_resp1", r_log[1].resp, RESP_SLVERR);
            chk("t5_data0", r_log[0].data, 128'h0);
            chk("t5_last0", r_log[0].last, 1'b0);
            chk("t5_last1", r_log[1].last, 1'b1);
        end

        // FIXED: address held
        clr_logs();
        do_ar(4'd8, 32'h40, 4'd2, 3'd4, BURST_FIXED);
        wait_idle(100);
        chk("t6_nreq", req_log.size(), 3);
        for (int i = 0; i < req_log.size(); i++)
            chk("t6_req_addr", req_log[i], 32'h40);

        // address wraps at 2^32
        clr_logs();
        do_ar(4'd9, 32'hFFFF_FFF0, 4'd1, 3'd4, BURST_INCR);
        wait_idle(100);
        chk("t7_nreq", req_log.size(), 2);
        if (req_log.size() == 2) begin
            chk("t7_addr0", req_log[0], 32'hFFFF_FFF0);
            chk("t7_addr1", req_log[1], 32'h0);
        end

        // random traffic
        rready_pct = 70; reqr_pct = 70; rsp_lat_max = 4;
        for (int n = 0; n < 150; n++) begin
            r = $urandom_range(0, 9);
            b = (r < 5) ? BURST_INCR : (r < 8) ? BURST_FIXED :
                (r == 8) ? BURST_WRAP : 2'b11;
            a = (n % 10 == 0) ? (32'hFFFF_FF00 | 32'($urandom_range(0, 255)))
                              : $urandom;
            do_ar(4'($urandom_range(0, 15)), a, 4'($urandom_range(0, 15)),
                  3'($urandom_range(0, 4)), b);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 6)) step();
        end
        wait_idle(6000);

        // reset in the middle of a burst
        rready_pct = 30; reqr_pct = 100;
        do_ar(4'd10, 32'h3000, 4'd15, 3'd4, BURST_INCR);
        repeat (5) step();
        #2 rst_n = 0;
        #1;
        chk("rstmid_rvalid", bus.rvalid, 1'b0);
        chk("rstmid_req_valid", bus.req_valid, 1'b0);
        chk("rstmid_arready", bus.arready, 1'b1);
        repeat (2) @(negedge clk);
        #2 rst_n = 1;
        rready_pct = 100;
        step();
        @(negedge clk);
        chk("rstmid_arready_after", bus.arready, 1'b1);
        step();
        clr_logs();
        do_ar(4'd11, 32'h80, 4'd1, 3'd3, BURST_INCR);
        wait_idle(100);
        chk("rec_nbeats", r_log.size(), 2);
        if (req_log.size() == 2) chk("rec_addr1", req_log[1], 32'h88);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, want $finish");
        $fatal(1);
    end

endmodule
